// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan chain sequencer.
// Contents: FSM state encoding and counter-width helper.
package scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register for the scan sequencer.
// Shifts right (bit 0 leaves first), new bits enter at the top. A bit counter
// tracks shifts since the last load/clear and flags the final bit of a pass.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load/load_data parallel load (also clears the bit counter)
//   clear          zero the register and the bit counter
//   shift, sin     shift one position, sin enters at bit CHAIN_LEN-1
//   data           current register contents (data[0] is the serial output)
//   last_bit       high while the counter sits on CHAIN_LEN-1
module scan_shift_reg #(
  parameter int CHAIN_LEN = 8,
  parameter int BCNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 sin,
  output logic [CHAIN_LEN-1:0] data,
  output logic                 last_bit
);

  logic [BCNT_W-1:0] bcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      bcnt <= '0;
    end else if (load) begin
      data <= load_data;
      bcnt <= '0;
    end else if (clear) begin
      data <= '0;
      bcnt <= '0;
    end else if (shift) begin
      data <= {sin, data[CHAIN_LEN-1:1]};
      bcnt <= bcnt + 1'b1;
    end
  end

  assign last_bit = (bcnt == BCNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan test sequencer for one chain of scan flip-flops.
// Accepts parallel patterns over valid/ready, shifts each into the chain
// (se=1), runs CAP_CYCLES capture cycles (se=0), and returns each captured
// response as a parallel word while the next pattern is being shifted in.
// Ports:
//   CLK, reset            clock, asynchronous active-high reset
//   start, num_pat        begin a run of num_pat patterns (sampled in IDLE)
//   busy, done            run in progress / one-cycle end-of-run pulse
//   pat_data/valid/ready  pattern input handshake (ready only in LOAD)
//   se, chain_en          scan enable and clock enable to the chain
//   scan_out, scan_in     serial data to chain head / from chain tail
//   resp_data/valid       captured response word, one-cycle valid pulse
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN  = 8,
  parameter int CAP_CYCLES = 1,
  parameter int PCNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PCNT_W-1:0]    num_pat,
  output logic                 busy,
  output logic                 done,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  output logic                 se,
  output logic                 chain_en,
  output logic                 scan_out,
  input  logic                 scan_in,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 resp_valid
);

  localparam int BCNT_W = cnt_w(CHAIN_LEN);
  localparam int CCNT_W = cnt_w(CAP_CYCLES);

  state_t              state;
  state_t              state_next;
  logic [PCNT_W-1:0]   pcnt;
  logic [PCNT_W-1:0]   pcnt_next;
  logic [CCNT_W-1:0]   ccnt;
  logic [CCNT_W-1:0]   ccnt_next;
  logic                first;
  logic                first_next;
  logic                sr_load;
  logic                sr_clear;
  logic                sr_shift;
  logic                last_bit;
  logic                resp_upd;
  logic                zero_start;
  logic [CHAIN_LEN-1:0] shreg;
  logic [CHAIN_LEN-1:0] shreg_shifted;

  scan_shift_reg #(
    .CHAIN_LEN (CHAIN_LEN),
    .BCNT_W    (BCNT_W)
  ) u_shreg (
    .clk       (CLK),
    .rst       (reset),
    .load      (sr_load),
    .load_data (pat_data),
    .clear     (sr_clear),
    .shift     (sr_shift),
    .sin       (scan_in),
    .data      (shreg),
    .last_bit  (last_bit)
  );

  // Value the shift register takes on this edge; the response is the word
  // after the final shift, which includes the bit sampled right now.
  assign shreg_shifted = {scan_in, shreg[CHAIN_LEN-1:1]};

  assign pat_ready = (state == ST_LOAD);
  assign scan_out  = shreg[0];

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pcnt  <= '0;
      ccnt  <= '0;
      first <= 1'b1;
    end else begin
      state <= state_next;
      pcnt  <= pcnt_next;
      ccnt  <= ccnt_next;
      first <= first_next;
    end
  end

  always_comb begin
    state_next = state;
    pcnt_next  = pcnt;
    ccnt_next  = ccnt;
    first_next = first;
    sr_load    = 1'b0;
    sr_clear   = 1'b0;
    sr_shift   = 1'b0;
    resp_upd   = 1'b0;
    zero_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_pat != '0) begin
            state_next = ST_LOAD;
            pcnt_next  = num_pat;
            first_next = 1'b1;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (pat_valid) begin
          sr_load    = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT, ST_UNLOAD: begin
        sr_shift = 1'b1;
        if (last_bit) begin
          // The first pass shifts out whatever the chain held before the run.
          resp_upd   = !first;
          ccnt_next  = '0;
          state_next = (state == ST_SHIFT) ? ST_CAPTURE : ST_DONE;
        end
      end
      ST_CAPTURE: begin
        if (ccnt == CCNT_W'(CAP_CYCLES - 1)) begin
          pcnt_next  = pcnt - 1'b1;
          first_next = 1'b0;
          if (pcnt != PCNT_W'(1)) begin
            state_next = ST_LOAD;
          end else begin
            sr_clear   = 1'b1;
            state_next = ST_UNLOAD;
          end
        end else begin
          ccnt_next = ccnt + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up
  // with the state they describe.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      se         <= 1'b0;
      chain_en   <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_DONE) || zero_start;
      se         <= (state_next == ST_SHIFT) || (state_next == ST_UNLOAD);
      chain_en   <= (state_next == ST_SHIFT) || (state_next == ST_UNLOAD) ||
                    (state_next == ST_CAPTURE);
      resp_valid <= resp_upd;
      if (resp_upd) begin
        resp_data <= shreg_shifted;
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 4-flop chain whose capture
// function inverts every flop, so each response is the bitwise inverse of
// the pattern that was loaded.
module tb_scan_chain_ctrl;
  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   num_pat = '0;
  logic [N-1:0] pat_data = '0;
  logic         pat_valid = 1'b0;
  logic         scan_in;
  logic         busy, done, pat_ready, se, chain_en, scan_out, resp_valid;
  logic [N-1:0] resp_data;

  int n_checks = 0;
  int n_err = 0;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAP_CYCLES(1), .PCNT_W(8)) dut (
    .CLK(CLK), .reset(reset), .start(start), .num_pat(num_pat),
    .busy(busy), .done(done), .pat_data(pat_data), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .se(se), .chain_en(chain_en), .scan_out(scan_out),
    .scan_in(scan_in), .resp_data(resp_data), .resp_valid(resp_valid)
  );

  always #5 CLK = ~CLK;

  // Chain model: shift toward the tail when se=1, invert every flop when se=0.
  logic [N-1:0] ff = '0;
  always @(posedge CLK) begin
    if (chain_en) begin
      if (se) ff <= {ff[N-2:0], scan_out};
      else    ff <= ~ff;
    end
  end
  assign scan_in = ff[N-1];

  // Monitor, sampled on the falling edge.
  logic [N-1:0] resp_q[$];
  int           resp_seidx[$];
  int           se_runs[$];
  int           cap_runs[$];
  int           se_run = 0;
  int           cap_run = 0;
  int           done_cnt = 0;
  int           act_cnt = 0;

  always @(negedge CLK) begin
    if (se) se_run++;
    else if (se_run != 0) begin se_runs.push_back(se_run); se_run = 0; end
    if (chain_en && !se) cap_run++;
    else if (cap_run != 0) begin cap_runs.push_back(cap_run); cap_run = 0; end
    if (resp_valid) begin
      resp_q.push_back(resp_data);
      resp_seidx.push_back(se_runs.size());
    end
    if (done) done_cnt++;
    if (busy || se || chain_en) act_cnt++;
  end

  logic [N-1:0] pat_tab[4];
  logic [N-1:0] exp_tab[4];
  logic         stall_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one sequence. stall_load selects which LOAD visit (0-based) withholds
  // pat_valid for stall_len cycles; poke pulses start mid-run.
  task automatic do_run(input int p, input int stall_load, input int stall_len,
                        input bit poke, output int done_at);
    int  k, loads, stall_left, cyc;
    bit  hs, prev_ready;
    k = 0; loads = 0; stall_left = 0; done_at = -1; prev_ready = 0;
    stall_bad = 1'b0;
    start = 1'b1; num_pat = 8'(p); pat_valid = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 200 && done_at < 0) begin
      if (done) done_at = cyc;
      if (pat_ready && !prev_ready) begin
        if (loads == stall_load) stall_left = stall_len;
        loads++;
      end
      prev_ready = pat_ready;
      if (pat_ready && stall_left > 0) begin
        pat_valid = 1'b0;
        stall_left--;
        if (se || chain_en) stall_bad = 1'b1;
      end else begin
        pat_valid = 1'b1;
        pat_data  = pat_tab[k];
      end
      if (poke && cyc == 3) begin start = 1'b1; num_pat = 8'd2; end
      else start = 1'b0;
      hs = pat_ready && pat_valid;
      @(posedge CLK); #1;
      cyc++;
      if (hs && k < 3) k++;
    end
    pat_valid = 1'b0;
    start = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
  endtask

  task automatic check_run(input string tag, input int p, input int exp_done,
                           input int done_at, input int rb, input int sb,
                           input int cb, input int db);
    int n4, n1;
    chk({tag, "_done_at"}, 32'(done_at), 32'(exp_done));
    chk({tag, "_done_pulses"}, 32'(done_cnt - db), 32'd1);
    chk({tag, "_nresp"}, 32'(resp_q.size() - rb), 32'(p));
    for (int i = 0; i < p && rb + i < resp_q.size(); i++)
      chk($sformatf("%s_resp%0d", tag, i), 32'(resp_q[rb + i]), 32'(exp_tab[i]));
    if (resp_seidx.size() > rb)
      chk({tag, "_first_resp_pos"}, 32'(resp_seidx[rb] - sb), 32'd2);
    n4 = 0;
    for (int i = sb; i < se_runs.size(); i++) if (se_runs[i] == N) n4++;
    chk({tag, "_se_runs"}, 32'(se_runs.size() - sb), 32'(p + 1));
    chk({tag, "_se_runs_len4"}, 32'(n4), 32'(p + 1));
    n1 = 0;
    for (int i = cb; i < cap_runs.size(); i++) if (cap_runs[i] == 1) n1++;
    chk({tag, "_cap_runs"}, 32'(cap_runs.size() - cb), 32'(p));
    chk({tag, "_cap_runs_len1"}, 32'(n1), 32'(p));
  endtask

  initial begin
    int rb, sb, cb, db, ab, done_at;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outs", 32'({busy, done, pat_ready, se, chain_en, scan_out, resp_valid, resp_data}), 32'd0);
    reset = 1'b0;
    @(posedge CLK); #1;
    chk("idle_outs", 32'({busy, done, pat_ready, se, chain_en, resp_valid}), 32'd0);

    // Single pattern 1010 -> 0101
    pat_tab[0] = 4'b1010; exp_tab[0] = 4'b0101;
    rb = resp_q.size(); sb = se_runs.size(); cb = cap_runs.size(); db = done_cnt;
    do_run(1, -1, 0, 1'b0, done_at);
    check_run("p1", 1, 11, done_at, rb, sb, cb, db);

    // Three patterns back to back
    pat_tab[0] = 4'h3; pat_tab[1] = 4'hC; pat_tab[2] = 4'h0; pat_tab[3] = 4'h0;
    exp_tab[0] = 4'hC; exp_tab[1] = 4'h3; exp_tab[2] = 4'hF;
    rb = resp_q.size(); sb = se_runs.size(); cb = cap_runs.size(); db = done_cnt;
    do_run(3, -1, 0, 1'b0, done_at);
    check_run("p3", 3, 23, done_at, rb, sb, cb, db);

    // Same patterns, second LOAD stalled for 5 cycles
    rb = resp_q.size(); sb = se_runs.size(); cb = cap_runs.size(); db = done_cnt;
    do_run(3, 1, 5, 1'b0, done_at);
    check_run("stall", 3, 28, done_at, rb, sb, cb, db);
    chk("stall_chain_held", 32'(stall_bad), 32'd0);

    // num_pat = 0
    db = done_cnt; ab = act_cnt;
    do_run(0, -1, 0, 1'b0, done_at);
    chk("p0_done_at", 32'(done_at), 32'd1);
    chk("p0_done_pulses", 32'(done_cnt - db), 32'd1);
    chk("p0_no_activity", 32'(act_cnt - ab), 32'd0);

    // start pulsed mid-run is ignored
    pat_tab[0] = 4'h6; exp_tab[0] = 4'h9;
    rb = resp_q.size(); sb = se_runs.size(); cb = cap_runs.size(); db = done_cnt;
    do_run(1, -1, 0, 1'b1, done_at);
    check_run("poke", 1, 11, done_at, rb, sb, cb, db);
    chk("poke_idle_after", 32'({busy, pat_ready}), 32'd0);

    // Reset during the second SHIFT cycle
    rb = resp_q.size(); db = done_cnt;
    start = 1'b1; num_pat = 8'd1; pat_data = 4'hA; pat_valid = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    pat_valid = 1'b0;
    @(posedge CLK); #1;
    chk("rst_in_shift", 32'({busy, se, chain_en}), 32'h7);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outs", 32'({busy, done, pat_ready, se, chain_en, scan_out, resp_valid, resp_data}), 32'd0);
    @(posedge CLK); #1;
    reset = 1'b0;
    repeat (15) begin @(posedge CLK); #1; end
    chk("rst_no_done", 32'(done_cnt - db), 32'd0);
    chk("rst_no_resp", 32'(resp_q.size() - rb), 32'd0);
    chk("rst_idle", 32'({busy, pat_ready, se, chain_en}), 32'd0);

    // Fresh run after reset
    pat_tab[0] = 4'b1010; exp_tab[0] = 4'b0101;
    rb = resp_q.size(); sb = se_runs.size(); cb = cap_runs.size(); db = done_cnt;
    do_run(1, -1, 0, 1'b0, done_at);
    check_run("after_rst", 1, 11, done_at, rb, sb, cb, db);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Scan test sequencer for a single chain of SCFF scan flip-flops. It accepts parallel test patterns over a valid/ready handshake and shifts each one into the chain with se=1. It then pulses a capture window with se=0 and returns each captured response as a parallel word. Unload of pattern k overlaps load of pattern k+1. The block sits between a pattern source/response checker and the chain's ScanIN/se/clock-enable pins.

Parameters:
CHAIN_LEN, 8, number of SCFFs in the chain (>=2)
CAP_CYCLES, 1, capture cycles per pattern with se=0 (>=1)
PCNT_W, 8, width of the pattern-count input

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
num_pat  in  PCNT_W  patterns in the run; sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
pat_data  in  CHAIN_LEN  pattern word; bit 0 is shifted first
pat_valid  in  1  pattern word valid
pat_ready  out  1  controller can accept a pattern (LOAD state only)
se  out  1  scan enable to chain; 1=shift, 0=capture/functional
chain_en  out  1  clock enable for the chain; high only in SHIFT/CAPTURE/UNLOAD
scan_out  out  1  serial data to chain ScanIN
scan_in  in  1  serial data from chain tail Q
resp_data  out  CHAIN_LEN  captured response; bit 0 is the first bit out of the chain
resp_valid  out  1  one-cycle pulse; no backpressure

Behaviour:
- Reset values: state=IDLE; busy, done, pat_ready, se, chain_en, scan_out, resp_valid all 0; resp_data=0; counters=0; first=1.
- All outputs are registered, except pat_ready and scan_out, which decode state and shreg[0].
- IDLE: start=1 with num_pat!=0 -> LOAD, pcnt<=num_pat, first<=1. start=1 with num_pat=0 -> done pulse next cycle, stay IDLE. start while busy is ignored.
- LOAD: pat_ready=1, se=0, chain_en=0, so the chain holds. On pat_valid&pat_ready: shreg<=pat_data, bcnt<=0 -> SHIFT. No timeout.
- SHIFT: se=1, chain_en=1, scan_out=shreg[0]. Each cycle shreg<={scan_in, shreg[N-1:1]} and bcnt++.
- SHIFT exit, on cycle bcnt==N-1:
  - If first==0: resp_data<=the post-shift shreg value, resp_valid=1 for that single cycle.
  - Go to CAPTURE.
- CAPTURE: se=0, chain_en=1 for exactly CAP_CYCLES cycles.
- CAPTURE exit, on the last cycle: pcnt--, first<=0.
  - If the new pcnt!=0 -> LOAD.
  - Otherwise shreg<=0, bcnt<=0 -> UNLOAD.
- UNLOAD: identical to SHIFT, with zeros shifted in. At bcnt==N-1: resp_data/resp_valid update as above -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- Per-pattern time with pat_valid held high: 1 (LOAD) + N + CAP_CYCLES cycles.
- Run time from start: P*(1+N+CAP_CYCLES) + N + 1 cycles to the done pulse.
- scan_in is sampled on the same edge at which the chain shifts, so the bit captured is tail Q before that edge.
- Counters: bcnt is $clog2(CHAIN_LEN) bits and wraps only via explicit clear. pcnt decrements never underflow because num_pat=0 is filtered in IDLE.
- Responses: exactly one resp_valid per pattern, in pattern order. The first resp_valid appears at the end of the second SHIFT or, for P=1, at the end of UNLOAD.
- Reset mid-run: immediate return to reset values, no done and no resp_valid. The chain contents are don't-care.
- pat_valid outside LOAD is ignored. pat_data is sampled only on the handshake cycle.

Decomposition:
- Package scan_ctrl_pkg: state enum (IDLE, LOAD, SHIFT, CAPTURE, UNLOAD, DONE) and localparam helpers for the counter width.
- One sub-module, scan_shift_reg: a CHAIN_LEN shift register with parallel load and clear, a serial in/out, and a bit counter with a last_bit flag.
- The FSM and the pattern counter stay in scan_chain_ctrl.

Test Plan:
- Bench chain model: N=4 SCFFs; in capture (se=0) each FF loads ~Q. num_pat=1, pat_data=4'b1010 -> resp_data=4'b0101, one resp_valid, done 11 cycles after start.
- num_pat=3 with patterns 4'h3, 4'hC, 4'h0 and pat_valid always high -> responses 4'hC, 4'h3, 4'hF in order, exactly 3 resp_valid pulses. The first pulse coincides with the end of the 2nd SHIFT.
- pat_valid withheld 5 cycles in the second LOAD -> se=0 and chain_en=0 throughout the stall; responses unchanged from the no-stall run.
- start with num_pat=0 -> done pulses the next cycle; busy, se and chain_en never rise.
- Assert reset in the 2nd SHIFT cycle -> all outputs 0 asynchronously, state IDLE, no done. A new run afterwards yields the correct response.
- start pulsed while busy -> ignored. se stays 1 for exactly 4 consecutive cycles and 0 for CAP_CYCLES cycles in every pattern.
